// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if
//   Bundles the decode, writeback and hazard-side signals of the register
//   file so they travel as one port.
//   master : the pipeline side. It drives the read addresses, the write
//            strobes and the issue strobe, and it receives the read data,
//            the busy flags, hazard and pend_count.
//   slave  : the register file itself.
//   Parameters: DATA_W is the register width. ADDR_W is the address width.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [ADDR_W-1:0] rd_addr3;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic [DATA_W-1:0] rd_data3;

  logic              wr_en_a;
  logic [ADDR_W-1:0] wr_addr_a;
  logic [DATA_W-1:0] wr_data_a;
  logic              wr_en_b;
  logic [ADDR_W-1:0] wr_addr_b;
  logic [DATA_W-1:0] wr_data_b;

  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;

  logic              busy1;
  logic              busy2;
  logic              busy3;
  logic              hazard;
  logic [ADDR_W:0]   pend_count;

  modport master (
    output rd_addr1, rd_addr2, rd_addr3,
    output wr_en_a, wr_addr_a, wr_data_a,
    output wr_en_b, wr_addr_b, wr_data_b,
    output issue_en, issue_addr,
    input  rd_data1, rd_data2, rd_data3,
    input  busy1, busy2, busy3, hazard, pend_count
  );

  modport slave (
    input  rd_addr1, rd_addr2, rd_addr3,
    input  wr_en_a, wr_addr_a, wr_data_a,
    input  wr_en_b, wr_addr_b, wr_data_b,
    input  issue_en, issue_addr,
    output rd_data1, rd_data2, rd_data3,
    output busy1, busy2, busy3, hazard, pend_count
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register file with these features:
//     - three combinational read ports,
//     - two prioritised write ports (A beats B on the same address),
//     - same-cycle write-to-read bypass,
//     - an optional hardwired zero register,
//     - a per-register pending scoreboard with a registered pending count.
//   Ports:
//     clock - rising-edge clock.
//     reset - synchronous, active-high. It clears the array, the
//             scoreboard and the count, and it forces the read data and
//             busy outputs to 0 while it is held.
//     bus   - regfile_scoreboard_if.slave. It carries the read ports, the
//             write ports A and B, the issue strobe, busy1-3, hazard and
//             pend_count.
//   Parameters:
//     DATA_W   - register width.
//     ADDR_W   - address width. The depth is 2**ADDR_W.
//     ZERO_REG - 1 makes register 0 read as zero. Writes and issues to
//                register 0 are then ignored.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  regfile_scoreboard_if.slave  bus
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic              ZERO_EN   = (ZERO_REG != 0);

  logic [DATA_W-1:0] regMem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [ADDR_W:0]   pendCount;

  logic              wrEffA;
  logic              wrEffB;
  logic              issueEff;
  logic              storeB;
  logic [ADDR_W-1:0] rdAddr [3];
  logic [DATA_W-1:0] rdData [3];
  logic [2:0]        busy;
  logic [DEPTH-1:0]  pendingNxt;
  logic [ADDR_W:0]   pendCountNxt;
  logic              riseIssue;
  logic              fallA;
  logic              fallB;

  function automatic logic isZeroAddr(input logic [ADDR_W-1:0] addr);
    return ZERO_EN && (addr == ADDR_ZERO);
  endfunction

  assign rdAddr[0] = bus.rd_addr1;
  assign rdAddr[1] = bus.rd_addr2;
  assign rdAddr[2] = bus.rd_addr3;

  // Drop any strobe that targets the hardwired zero register. B only
  // stores when A is not writing the same address.
  always_comb begin
    wrEffA   = bus.wr_en_a  && !isZeroAddr(bus.wr_addr_a);
    wrEffB   = bus.wr_en_b  && !isZeroAddr(bus.wr_addr_b);
    issueEff = bus.issue_en && !isZeroAddr(bus.issue_addr);
    storeB   = wrEffB && !(wrEffA && (bus.wr_addr_a == bus.wr_addr_b));
  end

  // Read mux with bypass, plus busy flags. A same-cycle write supplies the
  // value, so the matching busy flag is masked and no stall is needed.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      if (reset) begin
        rdData[p] = {DATA_W{1'b0}};
      end else if (isZeroAddr(rdAddr[p])) begin
        rdData[p] = {DATA_W{1'b0}};
      end else if (wrEffA && (bus.wr_addr_a == rdAddr[p])) begin
        rdData[p] = bus.wr_data_a;
      end else if (wrEffB && (bus.wr_addr_b == rdAddr[p])) begin
        rdData[p] = bus.wr_data_b;
      end else begin
        rdData[p] = regMem[rdAddr[p]];
      end
      busy[p] = !reset
             && !isZeroAddr(rdAddr[p])
             && pending[rdAddr[p]]
             && !(wrEffA && (bus.wr_addr_a == rdAddr[p]))
             && !(wrEffB && (bus.wr_addr_b == rdAddr[p]));
    end
  end

  // Next scoreboard vector. An issue to an address re-marks it pending even
  // when a write clears the same address, because the new producer wins.
  always_comb begin
    pendingNxt = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      pendingNxt[i] = (issueEff && (bus.issue_addr == ADDR_W'(i)))
                   || (pending[i]
                       && !(wrEffA && (bus.wr_addr_a == ADDR_W'(i)))
                       && !(wrEffB && (bus.wr_addr_b == ADDR_W'(i))));
    end
  end

  // Incremental count update. A bit that is set from 0 adds one, and a bit
  // that is cleared from 1 subtracts one. fallB is suppressed when A
  // already clears the same bit, so that bit is not counted twice.
  always_comb begin
    riseIssue = issueEff && !pending[bus.issue_addr];
    fallA     = wrEffA && pending[bus.wr_addr_a]
             && !(issueEff && (bus.issue_addr == bus.wr_addr_a));
    fallB     = wrEffB && pending[bus.wr_addr_b]
             && !(issueEff && (bus.issue_addr == bus.wr_addr_b))
             && !(wrEffA && (bus.wr_addr_a == bus.wr_addr_b));
    pendCountNxt = pendCount
                 + {{ADDR_W{1'b0}}, riseIssue}
                 - {{ADDR_W{1'b0}}, fallA}
                 - {{ADDR_W{1'b0}}, fallB};
  end

  // Storage array. Reset clears every entry and discards writes in that
  // cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regMem[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (storeB) begin
        regMem[bus.wr_addr_b] <= bus.wr_data_b;
      end
      if (wrEffA) begin
        regMem[bus.wr_addr_a] <= bus.wr_data_a;
      end
    end
  end

  // Scoreboard and pending-count registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending   <= {DEPTH{1'b0}};
      pendCount <= {(ADDR_W + 1){1'b0}};
    end else begin
      pending   <= pendingNxt;
      pendCount <= pendCountNxt;
    end
  end

  assign bus.rd_data1   = rdData[0];
  assign bus.rd_data2   = rdData[1];
  assign bus.rd_data3   = rdData[2];
  assign bus.busy1      = busy[0];
  assign bus.busy2      = busy[1];
  assign bus.busy3      = busy[2];
  assign bus.hazard     = busy[0] | busy[1];
  assign bus.pend_count = pendCount;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard.
//   Two instances share the same stimulus. One has ZERO_REG=1 and the
//   other has ZERO_REG=0.
//   The bench keeps an array-level model of the storage and the pending
//   set for each instance. The model is checked against both DUTs at
//   every falling edge, and directed literal checks pin the expected
//   values.
module tb_regfile_scoreboard;

  logic clock;
  logic reset;
  logic checkEn;
  int   testsRun;
  int   failCount;

  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) ifm ();
  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) ifz ();

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dutZero (
    .clock (clock),
    .reset (reset),
    .bus   (ifm)
  );

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dutPlain (
    .clock (clock),
    .reset (reset),
    .bus   (ifz)
  );

  assign ifz.rd_addr1   = ifm.rd_addr1;
  assign ifz.rd_addr2   = ifm.rd_addr2;
  assign ifz.rd_addr3   = ifm.rd_addr3;
  assign ifz.wr_en_a    = ifm.wr_en_a;
  assign ifz.wr_addr_a  = ifm.wr_addr_a;
  assign ifz.wr_data_a  = ifm.wr_data_a;
  assign ifz.wr_en_b    = ifm.wr_en_b;
  assign ifz.wr_addr_b  = ifm.wr_addr_b;
  assign ifz.wr_data_b  = ifm.wr_data_b;
  assign ifz.issue_en   = ifm.issue_en;
  assign ifz.issue_addr = ifm.issue_addr;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model state. Index 0 is the ZERO_REG=1 instance and index 1 is the
  // ZERO_REG=0 instance.
  logic [31:0] mMem  [2][32];
  logic        mPend [2][32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] portAddr(input int p);
    if (p == 0) return ifm.rd_addr1;
    else if (p == 1) return ifm.rd_addr2;
    else return ifm.rd_addr3;
  endfunction

  function automatic logic [31:0] dutData(input int d, input int p);
    if (d == 0) return (p == 0) ? ifm.rd_data1 : (p == 1) ? ifm.rd_data2 : ifm.rd_data3;
    else return (p == 0) ? ifz.rd_data1 : (p == 1) ? ifz.rd_data2 : ifz.rd_data3;
  endfunction

  function automatic logic dutBusy(input int d, input int p);
    if (d == 0) return (p == 0) ? ifm.busy1 : (p == 1) ? ifm.busy2 : ifm.busy3;
    else return (p == 0) ? ifz.busy1 : (p == 1) ? ifz.busy2 : ifz.busy3;
  endfunction

  // The value a reader must see this cycle: reset, then the zero register,
  // then the newest write data, then the stored value.
  function automatic logic [31:0] expRead(input int d, input logic [4:0] a);
    bit zr = (d == 0);
    if (reset) return 32'd0;
    if (zr && a == 5'd0) return 32'd0;
    if (ifm.wr_en_a && ifm.wr_addr_a == a) return ifm.wr_data_a;
    if (ifm.wr_en_b && ifm.wr_addr_b == a) return ifm.wr_data_b;
    return mMem[d][a];
  endfunction

  function automatic logic expBusy(input int d, input logic [4:0] a);
    bit zr = (d == 0);
    if (reset || (zr && a == 5'd0)) return 1'b0;
    if (ifm.wr_en_a && ifm.wr_addr_a == a) return 1'b0;
    if (ifm.wr_en_b && ifm.wr_addr_b == a) return 1'b0;
    return mPend[d][a];
  endfunction

  function automatic logic [5:0] expCount(input int d);
    int n = 0;
    for (int i = 0; i < 32; i++) n += mPend[d][i] ? 1 : 0;
    return 6'(n);
  endfunction

  // Model update at the rising edge. The strobes are read exactly as the
  // DUT samples them.
  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        for (int i = 0; i < 32; i++) begin
          mMem[d][i]  <= 32'd0;
          mPend[d][i] <= 1'b0;
        end
      end else begin
        if (ifm.wr_en_b && !(d == 0 && ifm.wr_addr_b == 5'd0)) begin
          mMem[d][ifm.wr_addr_b]  <= ifm.wr_data_b;
          mPend[d][ifm.wr_addr_b] <= 1'b0;
        end
        if (ifm.wr_en_a && !(d == 0 && ifm.wr_addr_a == 5'd0)) begin
          mMem[d][ifm.wr_addr_a]  <= ifm.wr_data_a;
          mPend[d][ifm.wr_addr_a] <= 1'b0;
        end
        if (ifm.issue_en && !(d == 0 && ifm.issue_addr == 5'd0)) begin
          mPend[d][ifm.issue_addr] <= 1'b1;
        end
      end
    end
  end

  // Compare every DUT output against the model at every falling edge.
  always @(negedge clock) begin
    if (checkEn) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 3; p++) begin
          chk($sformatf("cmp d%0d rd_data%0d", d, p + 1), dutData(d, p), expRead(d, portAddr(p)));
          chk($sformatf("cmp d%0d busy%0d", d, p + 1), dutBusy(d, p), expBusy(d, portAddr(p)));
        end
        chk($sformatf("cmp d%0d hazard", d), (d == 0) ? ifm.hazard : ifz.hazard,
            expBusy(d, portAddr(0)) | expBusy(d, portAddr(1)));
        chk($sformatf("cmp d%0d pend_count", d), (d == 0) ? ifm.pend_count : ifz.pend_count,
            expCount(d));
      end
    end
  end

  task automatic nextCycle();
    @(posedge clock);
    #1;
    reset          = 1'b0;
    ifm.wr_en_a    = 1'b0;
    ifm.wr_en_b    = 1'b0;
    ifm.issue_en   = 1'b0;
  endtask

  task automatic wrA(input logic [4:0] a, input logic [31:0] v);
    ifm.wr_en_a = 1'b1; ifm.wr_addr_a = a; ifm.wr_data_a = v;
  endtask

  task automatic wrB(input logic [4:0] a, input logic [31:0] v);
    ifm.wr_en_b = 1'b1; ifm.wr_addr_b = a; ifm.wr_data_b = v;
  endtask

  task automatic issue(input logic [4:0] a);
    ifm.issue_en = 1'b1; ifm.issue_addr = a;
  endtask

  initial begin
    testsRun = 0; failCount = 0; checkEn = 1'b0;
    reset = 1'b1;
    ifm.rd_addr1 = 5'd0; ifm.rd_addr2 = 5'd0; ifm.rd_addr3 = 5'd0;
    ifm.wr_en_a = 1'b0; ifm.wr_addr_a = 5'd0; ifm.wr_data_a = 32'd0;
    ifm.wr_en_b = 1'b0; ifm.wr_addr_b = 5'd0; ifm.wr_data_b = 32'd0;
    ifm.issue_en = 1'b0; ifm.issue_addr = 5'd0;
    @(posedge clock);
    checkEn = 1'b1;
    #1;
    @(negedge clock);
    chk("reset high busy1", ifm.busy1, 1'b0);
    nextCycle();
    @(negedge clock);
    chk("after reset pend_count", ifm.pend_count, 6'd0);

    // Reset clears stored data and pending state.
    nextCycle(); wrA(5'd5, 32'hDEADBEEF); issue(5'd9);
    nextCycle(); ifm.rd_addr1 = 5'd5; ifm.rd_addr2 = 5'd9;
    @(negedge clock);
    chk("r5 stored", ifm.rd_data1, 32'hDEADBEEF);
    chk("r9 busy", ifm.busy2, 1'b1);
    nextCycle(); reset = 1'b1;
    @(negedge clock);
    chk("busy2 in reset", ifm.busy2, 1'b0);
    chk("rd_data1 in reset", ifm.rd_data1, 32'd0);
    nextCycle();
    @(negedge clock);
    chk("r5 after reset", ifm.rd_data1, 32'd0);
    chk("pend after reset", ifm.pend_count, 6'd0);

    // Write-port priority and bypass.
    nextCycle(); wrA(5'd7, 32'h11111111); wrB(5'd7, 32'h22222222); ifm.rd_addr1 = 5'd7;
    @(negedge clock);
    chk("A wins bypass", ifm.rd_data1, 32'h11111111);
    nextCycle();
    @(negedge clock);
    chk("A wins stored", ifm.rd_data1, 32'h11111111);
    nextCycle(); wrB(5'd8, 32'h33); wrA(5'd9, 32'h44);
    nextCycle(); ifm.rd_addr1 = 5'd8; ifm.rd_addr2 = 5'd9;
    @(negedge clock);
    chk("B r8 stored", ifm.rd_data1, 32'h33);
    chk("A r9 stored", ifm.rd_data2, 32'h44);

    // Zero register with and without ZERO_REG.
    nextCycle(); wrA(5'd0, 32'hFFFFFFFF); issue(5'd0); ifm.rd_addr2 = 5'd0;
    @(negedge clock);
    chk("r0 zero bypass", ifm.rd_data2, 32'd0);
    chk("r0 zero busy", ifm.busy2, 1'b0);
    chk("r0 plain bypass", ifz.rd_data2, 32'hFFFFFFFF);
    nextCycle();
    @(negedge clock);
    chk("r0 zero read", ifm.rd_data2, 32'd0);
    chk("r0 zero pend", ifm.pend_count, 6'd0);
    chk("r0 plain read", ifz.rd_data2, 32'hFFFFFFFF);
    chk("r0 plain busy", ifz.busy2, 1'b1);
    chk("r0 plain pend", ifz.pend_count, 6'd1);
    nextCycle(); wrB(5'd0, 32'd0);

    // Scoreboard issue then write-back.
    nextCycle(); issue(5'd3);
    nextCycle(); ifm.rd_addr1 = 5'd3;
    @(negedge clock);
    chk("r3 busy1", ifm.busy1, 1'b1);
    chk("r3 hazard", ifm.hazard, 1'b1);
    chk("r3 pend", ifm.pend_count, 6'd1);
    nextCycle(); wrA(5'd3, 32'h55);
    @(negedge clock);
    chk("r3 wb busy1", ifm.busy1, 1'b0);
    chk("r3 wb data", ifm.rd_data1, 32'h55);
    chk("r3 wb hazard", ifm.hazard, 1'b0);
    nextCycle();
    @(negedge clock);
    chk("r3 pend cleared", ifm.pend_count, 6'd0);

    // Simultaneous issue and write to the same register: the set wins.
    nextCycle(); issue(5'd4);
    nextCycle(); issue(5'd4); wrB(5'd4, 32'h66);
    nextCycle(); ifm.rd_addr1 = 5'd4;
    @(negedge clock);
    chk("r4 still pend", ifm.pend_count, 6'd1);
    chk("r4 still busy", ifm.busy1, 1'b1);
    chk("r4 data", ifm.rd_data1, 32'h66);
    nextCycle(); issue(5'd2);
    nextCycle(); issue(5'd6); wrA(5'd2, 32'h77);
    nextCycle(); ifm.rd_addr1 = 5'd6; ifm.rd_addr2 = 5'd2;
    @(negedge clock);
    chk("net zero pend", ifm.pend_count, 6'd2);
    chk("r6 busy", ifm.busy1, 1'b1);
    chk("r2 not busy", ifm.busy2, 1'b0);

    // Full count, then reset together with a write.
    nextCycle(); wrA(5'd10, 32'h1234);
    for (int i = 1; i < 32; i++) begin
      nextCycle(); issue(5'(i)); ifm.rd_addr3 = 5'(i);
    end
    nextCycle(); ifm.rd_addr1 = 5'd10;
    @(negedge clock);
    chk("full pend zero", ifm.pend_count, 6'd31);
    chk("full pend plain", ifz.pend_count, 6'd31);
    nextCycle(); reset = 1'b1; wrA(5'd10, 32'hABCD);
    @(negedge clock);
    chk("r10 in reset", ifm.rd_data1, 32'd0);
    nextCycle();
    @(negedge clock);
    chk("pend after mid reset", ifm.pend_count, 6'd0);
    chk("r10 after mid reset", ifm.rd_data1, 32'd0);
    nextCycle();
    @(negedge clock);

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
